// File: rtl/ahb_pkg.sv
// Shared AHB encodings, SRAM slave FSM states and byte-lane helpers.
package ahb_pkg;

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_BUSY   = 2'b01,
    TR_NONSEQ = 2'b10,
    TR_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    SZ_BYTE = 3'b000,
    SZ_HALF = 3'b001,
    SZ_WORD = 3'b010
  } hsize_t;

  typedef enum logic [1:0] {
    RESP_OKAY  = 2'b00,
    RESP_ERROR = 2'b01
  } hresp_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_t;

  // True when the size is supported and the low address bits are aligned to it.
  function automatic logic size_ok(input logic [2:0] size, input logic [1:0] lsb);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~lsb[0];
      SZ_WORD: return lsb == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // Little-endian byte lanes touched by an aligned access.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lsb);
    case (size)
      SZ_BYTE: return 4'b0001 << lsb;
      SZ_HALF: return lsb[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// Word-organised storage: one byte-enabled synchronous write port, one combinational read port.
module ahb_sram_mem #(
  parameter int unsigned WORDS = 256,
  parameter int unsigned AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] store [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) store[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = store[raddr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with configurable wait states and two-cycle ERROR responses.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int unsigned MEM_WORDS   = 256,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA
);

  localparam int unsigned ABITS     = $clog2(4 * MEM_WORDS);
  localparam int unsigned WBITS     = ABITS - 2;
  localparam logic [1:0]  WAIT_LOAD = (WAIT_STATES == 0) ? 2'd0 : 2'(WAIT_STATES - 1);

  state_t             state, state_nxt;
  logic [1:0]         cnt, cnt_nxt;
  logic               dp_valid, dp_write;
  logic [ABITS-1:0]   dp_addr;
  logic [2:0]         dp_size;
  logic               ready, accept, legal, we;
  logic [3:0]         be;
  logic [31:0]        rdata;
  logic               unused_burst;

  assign unused_burst = ^HBURST;

  // Only IDLE and ERR2 end a data phase, so only they may take a new address phase.
  assign ready  = (state == ST_IDLE) || (state == ST_ERR2);
  assign accept = ready && HSEL && HREADY && ((HTRANS == TR_NONSEQ) || (HTRANS == TR_SEQ));
  assign legal  = ~(|HADDR[31:ABITS]) && size_ok(HSIZE, HADDR[1:0]);

  assign we = (state == ST_IDLE) && dp_valid && dp_write;
  assign be = lane_mask(dp_size, dp_addr[1:0]);

  ahb_sram_mem #(
    .WORDS (MEM_WORDS),
    .AW    (WBITS)
  ) u_mem (
    .clk   (HCLK),
    .we    (we),
    .be    (be),
    .waddr (dp_addr[ABITS-1:2]),
    .wdata (HWDATA),
    .raddr (dp_addr[ABITS-1:2]),
    .rdata (rdata)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
      dp_size  <= '0;
    end else if (ready) begin
      dp_valid <= accept && legal;
      if (accept) begin
        dp_write <= HWRITE;
        dp_addr  <= HADDR[ABITS-1:0];
        dp_size  <= HSIZE;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    HREADYOUT = 1'b1;
    HRESP     = RESP_OKAY;
    HRDATA    = '0;
    case (state)
      ST_IDLE, ST_ERR2: begin
        if (state == ST_ERR2) HRESP = RESP_ERROR;
        if (state == ST_IDLE && dp_valid && !dp_write) HRDATA = rdata;
        state_nxt = ST_IDLE;
        if (accept) begin
          if (!legal) begin
            state_nxt = ST_ERR1;
          end else if (WAIT_STATES != 0) begin
            state_nxt = ST_WAIT;
            cnt_nxt   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        if (cnt == 2'd0) state_nxt = ST_IDLE;
        else             cnt_nxt   = cnt - 2'd1;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = RESP_ERROR;
        state_nxt = ST_ERR2;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
